// File: rtl/sliding_puzzle_ctrl_if.sv
// Command and board-view signals between the puzzle engine, its input front end
// and the display driver.
interface sliding_puzzle_ctrl_if #(
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int TILE_W = 3,
  parameter int CNT_W  = 8
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);

  logic                  load;
  logic [N*TILE_W-1:0]   load_board;
  logic [3:0]            act;
  logic                  undo;
  logic                  restart;
  logic [N*TILE_W-1:0]   board;
  logic [IDX_W-1:0]      blank_idx;
  logic [CNT_W-1:0]      move_cnt;
  logic                  win_flag;
  logic                  illegal;

  modport master (
    output load, load_board, act, undo, restart,
    input  board, blank_idx, move_cnt, win_flag, illegal
  );

  modport slave (
    input  load, load_board, act, undo, restart,
    output board, blank_idx, move_cnt, win_flag, illegal
  );
endinterface

// File: rtl/sliding_puzzle_ctrl.sv
// ROWS x COLS sliding-tile puzzle engine: blank moves, move counting, circular
// undo history, restart to the last loaded board and solved detection.
module sliding_puzzle_ctrl #(
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int TILE_W     = 3,
  parameter int HIST_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                 clk_d,
  input  logic                 reset,
  sliding_puzzle_ctrl_if.slave bus
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);
  localparam int HW    = $clog2(HIST_DEPTH);
  localparam logic [TILE_W-1:0] BLANK = TILE_W'(N);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_SOLVED} state_t;

  state_t              r_state, w_next_state;
  logic [TILE_W-1:0]   r_cells [N];
  logic [TILE_W-1:0]   r_saved [N];
  logic [TILE_W-1:0]   w_ld_cells [N];
  logic [IDX_W-1:0]    r_blank, r_saved_blank;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_hist [HIST_DEPTH];
  logic [HW-1:0]       r_wptr;
  logic [HW:0]         r_occ;
  logic                r_win, r_illegal;

  logic                w_solved, w_ld_found, w_legal, w_use_undo;
  logic [IDX_W-1:0]    w_ld_blank, w_nb;
  logic [HW-1:0]       w_wprev;
  logic [1:0]          w_adir, w_dir;
  logic                w_do_load, w_do_restart, w_do_undo, w_do_move, w_reject;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign w_ld_cells[g] = bus.load_board[(N-1-g)*TILE_W +: TILE_W];
    assign bus.board[(N-1-g)*TILE_W +: TILE_W] = r_cells[g];
  end

  assign bus.blank_idx = r_blank;
  assign bus.move_cnt  = r_cnt;
  assign bus.win_flag  = r_win;
  assign bus.illegal   = r_illegal;

  always_comb begin
    w_solved   = 1'b1;
    w_ld_found = 1'b0;
    w_ld_blank = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_cells[IDX_W'(i)] != BLANK && r_cells[IDX_W'(i)] != TILE_W'(i))
        w_solved = 1'b0;
      if (!w_ld_found && w_ld_cells[IDX_W'(i)] == BLANK) begin
        w_ld_found = 1'b1;
        w_ld_blank = IDX_W'(i);
      end
    end
  end

  // Undo replays the inverse of the newest pushed direction (codes differ by bit 1).
  assign w_wprev    = r_wptr - HW'(1);
  assign w_use_undo = !bus.load && !bus.restart && bus.undo;

  always_comb begin
    case (bus.act)
      4'b0001: w_adir = 2'd0;
      4'b0010: w_adir = 2'd1;
      4'b0100: w_adir = 2'd2;
      default: w_adir = 2'd3;
    endcase
    w_dir = w_use_undo ? (r_hist[w_wprev] ^ 2'b10) : w_adir;
  end

  always_comb begin
    int unsigned b, row, col, nb;
    b   = 32'(r_blank);
    row = b / COLS;
    col = b % COLS;
    case (w_dir)
      2'd0:    begin w_legal = (row != 0);        nb = b - COLS; end
      2'd1:    begin w_legal = (col != COLS - 1); nb = b + 1;    end
      2'd2:    begin w_legal = (row != ROWS - 1); nb = b + COLS; end
      default: begin w_legal = (col != 0);        nb = b - 1;    end
    endcase
    w_nb = w_legal ? IDX_W'(nb) : r_blank;
  end

  always_comb begin
    w_next_state = r_state;
    w_do_load    = 1'b0;
    w_do_restart = 1'b0;
    w_do_undo    = 1'b0;
    w_do_move    = 1'b0;
    w_reject     = 1'b0;
    if (bus.load) begin
      if (w_ld_found) begin
        w_do_load    = 1'b1;
        w_next_state = S_PLAY;
      end else begin
        w_reject = 1'b1;
      end
    end else if (bus.restart && r_state != S_IDLE) begin
      w_do_restart = 1'b1;
      w_next_state = S_PLAY;
    end else if (bus.undo && r_state != S_IDLE) begin
      if (r_occ == '0) begin
        w_reject = 1'b1;
      end else begin
        w_do_undo    = 1'b1;
        w_next_state = S_PLAY;
      end
    end else if (bus.act != 4'b0000 && r_state == S_PLAY) begin
      if (!$onehot(bus.act) || !w_legal) w_reject  = 1'b1;
      else                               w_do_move = 1'b1;
    end
    // Win check uses the current board, so it only applies when no command reshapes it.
    if (r_state == S_PLAY && w_solved &&
        !(w_do_load || w_do_restart || w_do_undo || w_do_move))
      w_next_state = S_SOLVED;
  end

  always_ff @(posedge clk_d or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk_d or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_cells[IDX_W'(i)] <= (i == N - 1) ? BLANK : TILE_W'(i);
        r_saved[IDX_W'(i)] <= (i == N - 1) ? BLANK : TILE_W'(i);
      end
      for (int unsigned i = 0; i < HIST_DEPTH; i++) r_hist[HW'(i)] <= '0;
      r_blank       <= IDX_W'(N - 1);
      r_saved_blank <= IDX_W'(N - 1);
      r_cnt         <= '0;
      r_wptr        <= '0;
      r_occ         <= '0;
      r_win         <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_win     <= (w_next_state == S_SOLVED);
      r_illegal <= w_reject;
      if (w_do_load) begin
        r_cells       <= w_ld_cells;
        r_saved       <= w_ld_cells;
        r_blank       <= w_ld_blank;
        r_saved_blank <= w_ld_blank;
        r_cnt         <= '0;
        r_wptr        <= '0;
        r_occ         <= '0;
      end else if (w_do_restart) begin
        r_cells <= r_saved;
        r_blank <= r_saved_blank;
        r_cnt   <= '0;
        r_wptr  <= '0;
        r_occ   <= '0;
      end else if (w_do_undo || w_do_move) begin
        r_cells[r_blank] <= r_cells[w_nb];
        r_cells[w_nb]    <= r_cells[r_blank];
        r_blank          <= w_nb;
        if (w_do_undo) begin
          r_wptr <= w_wprev;
          r_occ  <= r_occ - (HW+1)'(1);
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end else begin
          r_hist[r_wptr] <= w_dir;
          r_wptr         <= r_wptr + HW'(1);
          if (r_occ != (HW+1)'(HIST_DEPTH)) r_occ <= r_occ + (HW+1)'(1);
          if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule
